// File: rtl/maxmin_pkg.sv
// ----------------------------------------------------------------------------
// maxmin_pkg
// Shared definitions for the max/min sequencing controller of the skin-colour
// segmentation front end.
//   state_t         : controller FSM states (IDLE, MAX, MIN, CAP, DONE)
//   IDX_R/G/B       : channel index codes reported on the *_idx outputs
//   DEFAULT_W       : default channel width in bits
// ----------------------------------------------------------------------------
package maxmin_pkg;

    localparam int DEFAULT_W = 10;

    localparam logic [1:0] IDX_R = 2'd0;
    localparam logic [1:0] IDX_G = 2'd1;
    localparam logic [1:0] IDX_B = 2'd2;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        MAX  = 3'd1,
        MIN  = 3'd2,
        CAP  = 3'd3,
        DONE = 3'd4
    } state_t;

endpackage

// File: rtl/max3_idx.sv
// ----------------------------------------------------------------------------
// max3_idx
// Registered 3-input maximum with the index of the winning input.
// Ties resolve to the lowest index (a before b before c). Fed with inverted
// operands it yields ~min, and the same tie rule then favours the lowest index
// among equal minima.
// Ports:
//   clk, rst_n       : clock, asynchronous active-low reset
//   i_a, i_b, i_c    : operands (index 0, 1, 2)
//   o_max            : largest operand, one cycle after the inputs
//   o_idx            : index of o_max, one cycle after the inputs
// ----------------------------------------------------------------------------
module max3_idx
    import maxmin_pkg::*;
#(
    parameter int W = DEFAULT_W
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] i_a,
    input  logic [W-1:0] i_b,
    input  logic [W-1:0] i_c,
    output logic [W-1:0] o_max,
    output logic [1:0]   o_idx
);

    logic [W-1:0] w_max;
    logic [1:0]   w_idx;

    always_comb begin
        w_max = i_c;
        w_idx = IDX_B;
        if ((i_a >= i_b) && (i_a >= i_c)) begin
            w_max = i_a;
            w_idx = IDX_R;
        end else if (i_b >= i_c) begin
            w_max = i_b;
            w_idx = IDX_G;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_max <= '0;
            o_idx <= IDX_R;
        end else begin
            o_max <= w_max;
            o_idx <= w_idx;
        end
    end

endmodule

// File: rtl/maxmin_seq_ctrl.sv
// ----------------------------------------------------------------------------
// maxmin_seq_ctrl
// Per-pixel controller producing max, min, their channel indices and
// delta = max - min of an RGB pixel, time-sharing one registered max3_idx.
// The min pass drives the comparator with inverted channels: max(~r,~g,~b)=~min.
// Optional build macro: MAXMIN_GRAY_BYPASS_EN -- gray pixels (r==g==b) skip
// the comparator and go straight to DONE (result one edge after accept).
// Ports:
//   clk, rst_n                  : clock, asynchronous active-low reset
//   in_valid/in_ready           : input handshake; in_ready only in IDLE
//   in_r, in_g, in_b            : pixel channels 0/1/2
//   out_valid/out_ready         : output handshake; result held until taken
//   out_max, out_min, out_delta : result values
//   out_max_idx, out_min_idx    : channel index of max / min (0=r,1=g,2=b)
//   busy                        : controller is not in IDLE
// ----------------------------------------------------------------------------
module maxmin_seq_ctrl
    import maxmin_pkg::*;
#(
    parameter int W = DEFAULT_W
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_r,
    input  logic [W-1:0] in_g,
    input  logic [W-1:0] in_b,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_max,
    output logic [W-1:0] out_min,
    output logic [W-1:0] out_delta,
    output logic [1:0]   out_max_idx,
    output logic [1:0]   out_min_idx,
    output logic         busy
);

    state_t       r_state;
    logic [W-1:0] r_r, r_g, r_b;
    logic [W-1:0] r_max;
    logic [1:0]   r_max_idx;
    logic         r_in_ready, r_out_valid, r_busy;
    logic [W-1:0] r_out_max, r_out_min, r_out_delta;
    logic [1:0]   r_out_max_idx, r_out_min_idx;

    logic         w_inv;
    logic [W-1:0] w_cmp_a, w_cmp_b, w_cmp_c;
    logic [W-1:0] w_cmp_max, w_min;
    logic [1:0]   w_cmp_idx;

    // Operands are inverted only while the min pass is being launched.
    assign w_inv   = (r_state == MIN);
    assign w_cmp_a = w_inv ? ~r_r : r_r;
    assign w_cmp_b = w_inv ? ~r_g : r_g;
    assign w_cmp_c = w_inv ? ~r_b : r_b;
    assign w_min   = ~w_cmp_max;

    max3_idx #(.W(W)) u_max3 (
        .clk   (clk),
        .rst_n (rst_n),
        .i_a   (w_cmp_a),
        .i_b   (w_cmp_b),
        .i_c   (w_cmp_c),
        .o_max (w_cmp_max),
        .o_idx (w_cmp_idx)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= IDLE;
            r_r           <= '0;
            r_g           <= '0;
            r_b           <= '0;
            r_max         <= '0;
            r_max_idx     <= IDX_R;
            r_in_ready    <= 1'b0;
            r_out_valid   <= 1'b0;
            r_busy        <= 1'b0;
            r_out_max     <= '0;
            r_out_min     <= '0;
            r_out_delta   <= '0;
            r_out_max_idx <= IDX_R;
            r_out_min_idx <= IDX_R;
        end else begin
            case (r_state)
                IDLE: begin
                    // in_ready is registered, so it first rises one edge after reset release.
                    if (r_in_ready && in_valid) begin
                        r_r        <= in_r;
                        r_g        <= in_g;
                        r_b        <= in_b;
                        r_in_ready <= 1'b0;
                        r_busy     <= 1'b1;
`ifdef MAXMIN_GRAY_BYPASS_EN
                        if ((in_r == in_g) && (in_g == in_b)) begin
                            r_out_max     <= in_r;
                            r_out_min     <= in_r;
                            r_out_delta   <= '0;
                            r_out_max_idx <= IDX_R;
                            r_out_min_idx <= IDX_R;
                            r_out_valid   <= 1'b1;
                            r_state       <= DONE;
                        end else begin
                            r_state <= MAX;
                        end
`else
                        r_state <= MAX;
`endif
                    end else begin
                        r_in_ready <= 1'b1;
                    end
                end
                MAX: begin
                    r_state <= MIN;
                end
                MIN: begin
                    r_max     <= w_cmp_max;
                    r_max_idx <= w_cmp_idx;
                    r_state   <= CAP;
                end
                CAP: begin
                    // Outputs are loaded only here so they never change while out_valid is low.
                    r_out_max     <= r_max;
                    r_out_max_idx <= r_max_idx;
                    r_out_min     <= w_min;
                    r_out_min_idx <= w_cmp_idx;
                    r_out_delta   <= r_max - w_min;
                    r_out_valid   <= 1'b1;
                    r_state       <= DONE;
                end
                DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_busy      <= 1'b0;
                        r_state     <= IDLE;
                    end
                end
                default: begin
                    r_out_valid <= 1'b0;
                    r_in_ready  <= 1'b0;
                    r_busy      <= 1'b0;
                    r_state     <= IDLE;
                end
            endcase
        end
    end

    assign in_ready    = r_in_ready;
    assign out_valid   = r_out_valid;
    assign busy        = r_busy;
    assign out_max     = r_out_max;
    assign out_min     = r_out_min;
    assign out_delta   = r_out_delta;
    assign out_max_idx = r_out_max_idx;
    assign out_min_idx = r_out_min_idx;

endmodule

// File: doc/maxmin_seq_ctrl.md
Name: maxmin_seq_ctrl

Overview:
- Per-pixel controller for the skin-colour segmentation front end.
- Time-shares one registered 3-input max comparator to produce max, min, their channel indices and delta (max − min) of an RGB pixel, ahead of the HSV/threshold stages.
- Uses a valid/ready handshake on both sides.
- Min is computed by feeding bitwise-inverted operands to the same comparator: max(~r,~g,~b) = ~min.

Parameters:
- W, 10: channel width in bits; applies to the r/g/b inputs and the max/min/delta outputs.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  pixel present on in_r/in_g/in_b
- in_ready  out  1  block accepts a pixel this cycle
- in_r  in  W  channel 0
- in_g  in  W  channel 1
- in_b  in  W  channel 2
- out_valid  out  1  result valid, held until accepted
- out_ready  in  1  downstream accepts the result
- out_max  out  W  largest channel value
- out_min  out  W  smallest channel value
- out_delta  out  W  out_max − out_min
- out_max_idx  out  2  0=r, 1=g, 2=b
- out_min_idx  out  2  0=r, 1=g, 2=b
- busy  out  1  state != IDLE

Behaviour:
- Reset (rst_n low, asynchronous): state IDLE; all outputs 0, including in_ready; operand and result registers 0. in_ready rises at the first clk edge after rst_n release.
- Reset mid-operation: the in-flight pixel is discarded with no output. Handshakes are ignored while rst_n is low.
- Shared comparator (max3_idx), 1-cycle registered latency. Tie rule, lowest index wins:
  - a if a>=b && a>=c;
  - else b if b>=c;
  - else c.
  - Through inversion, min ties also go to the lowest index.
- FSM states: IDLE, MAX, MIN, CAP, DONE.
  - IDLE: in_ready=1. On in_valid&in_ready, latch r/g/b → MAX.
  - MAX: drive comparator with r,g,b → MIN.
  - MIN: capture comparator output as max/max_idx; drive ~r,~g,~b → CAP.
  - CAP: capture ~comparator output as min/min_idx; compute delta → DONE.
  - DONE: out_valid=1, outputs stable. On out_ready → IDLE. If out_ready is low, hold indefinitely with no overflow and no new accept.
- Timing:
  - out_valid is asserted 3 clk edges after the accepting edge.
  - Minimum pixel period is 5 cycles.
  - in_ready is 0 in every state except IDLE, so there is never a simultaneous accept and in-flight pixel.
- Width: delta = max − min in W bits. It is never negative because max >= min by construction.
- out_valid drops the cycle after the accepting out_ready edge. Outputs keep their last value while out_valid=0.

Optional Feature:
- Macro: MAXMIN_GRAY_BYPASS_EN.
- Defined: if r==g==b at accept, go IDLE → DONE directly.
  - out_valid after 1 edge.
  - max=min=r, delta=0, max_idx=min_idx=0.
  - The comparator is not exercised.
- Undefined: gray pixels take the normal 3-edge path. Results are identical except for latency.

Decomposition:
- Shared package maxmin_pkg holds:
  - the FSM state enum (IDLE, MAX, MIN, CAP, DONE);
  - channel index constants IDX_R=0, IDX_G=1, IDX_B=2;
  - default W=10.
- One sub-module: max3_idx, a registered 3-input max plus 2-bit index, parameterised by W, instantiated once.

Test Plan:
- Basic: r=200, g=100, b=50 → out_max=200, max_idx=0, out_min=50, min_idx=2, delta=150; out_valid exactly 3 edges after accept.
- Ties: r=300, g=300, b=10 → max=300 idx 0, min=10 idx 2. Also r=5, g=900, b=5 → max=900 idx 1, min=5 idx 0.
- Backpressure: hold out_ready=0 for 20 cycles with in_valid=1 → outputs stable, in_ready=0 throughout. Release → one handshake, IDLE, next pixel accepted 1 cycle later.
- Gray pixel: r=g=b=512 → max=min=512, delta=0, idx 0/0. Latency is 1 edge with MAXMIN_GRAY_BYPASS_EN, 3 edges without.
- Reset mid-op: pull rst_n low in MIN state → all outputs 0 immediately, no out_valid after release. Next pixel (r=1023, g=0, b=0) gives delta=1023, max_idx 0, min_idx 1.
- Streaming: 100 random pixels with random out_ready → results match a reference model in order, minimum period 5 cycles, no lost or duplicated results.
